// File: rtl/cla4_df.sv
// cla4_df: registered carry-lookahead adder built from 4-bit lookahead
// groups chained through a second-level lookahead over group P/G.
// Ports: clk, rst (sync, active-high), a, b, cin -> sum, cout, pg, gg
// (all outputs registered, one-cycle latency, no handshake).
module cla4_df #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             pg,
    output logic             gg
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] s;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    ggn;
    logic [NG:0]      gc;
    logic             gg_c;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < NG; k++) begin : grp
        logic [3:0] gi;
        logic [3:0] pi;
        logic [3:0] ci;

        assign gi    = g[4*k +: 4];
        assign pi    = p[4*k +: 4];
        assign ci[0] = gc[k];
        assign ci[1] = gi[0]
                     | (pi[0] & ci[0]);
        assign ci[2] = gi[1]
                     | (pi[1] & gi[0])
                     | (pi[1] & pi[0] & ci[0]);
        assign ci[3] = gi[2]
                     | (pi[2] & gi[1])
                     | (pi[2] & pi[1] & gi[0])
                     | (pi[2] & pi[1] & pi[0] & ci[0]);

        assign s[4*k +: 4] = pi ^ ci;

        assign gp[k]  = &pi;
        assign ggn[k] = gi[3]
                      | (pi[3] & gi[2])
                      | (pi[3] & pi[2] & gi[1])
                      | (pi[3] & pi[2] & pi[1] & gi[0]);
    end

    // Second level: each group carry-in is a flat sum of products over
    // the lower groups' G terms (masked by the intervening P terms) plus
    // cin masked by all lower P terms, so no carry ripples between groups.
    always_comb begin
        logic acc;
        logic prod;
        gc    = '0;
        gc[0] = cin;
        gg_c  = 1'b0;
        for (int k = 1; k <= NG; k++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                acc  = acc | (ggn[j] & prod);
                prod = prod & gp[j];
            end
            gc[k] = acc | (prod & cin);
            if (k == NG) begin
                gg_c = acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            pg   <= 1'b0;
            gg   <= 1'b0;
        end else begin
            sum  <= s;
            cout <= gc[NG];
            pg   <= &p;
            gg   <= gg_c;
        end
    end

endmodule

// File: tb/tb_cla4_df.sv
// tb_cla4_df: scoreboard bench for cla4_df; driver pushes expected
// results per edge, monitor pops and compares one cycle later.
module tb_cla4_df;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       pg;
    logic       gg;

    typedef struct {
        logic [3:0] sum;
        logic       cout;
        logic       pg;
        logic       gg;
        string      name;
    } exp_t;

    exp_t q[$];

    int tests = 0;
    int fails = 0;

    cla4_df #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .sum (sum),
        .cout(cout),
        .pg  (pg),
        .gg  (gg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors: rst, a, b, cin, hand-computed sum/cout/pg/gg.
    typedef struct {
        logic       r;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] s;
        logic       co;
        logic       p;
        logic       g;
        string      name;
    } vec_t;

    vec_t dir[$] = '{
        '{1'b1, 4'b1010, 4'b0110, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, "rst0"},
        '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, "rst1"},
        '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "zero"},
        '{1'b0, 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, "alt"},
        '{1'b0, 4'b1100, 4'b1100, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b1, "gen"},
        '{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, "chain"},
        '{1'b0, 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, "prop0"},
        '{1'b0, 4'b0111, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, "wrap"},
        '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, "rstmid"},
        '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, "max"}
    };

    task automatic push_model(input logic r, input string nm);
        exp_t e;
        logic [4:0] t;
        logic [4:0] t0;
        t  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        t0 = {1'b0, a} + {1'b0, b};
        e.name = nm;
        if (r) begin
            e.sum  = '0;
            e.cout = 1'b0;
            e.pg   = 1'b0;
            e.gg   = 1'b0;
        end else begin
            e.sum  = t[3:0];
            e.cout = t[4];
            e.pg   = &(a ^ b);
            e.gg   = t0[4];
        end
        q.push_back(e);
    endtask

    // Monitor: one result per edge, sampled 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (sum !== e.sum || cout !== e.cout ||
                    pg !== e.pg || gg !== e.gg) begin
                    fails++;
                    $display("FAIL %s: got sum=%b cout=%b pg=%b gg=%b, need sum=%b cout=%b pg=%b gg=%b",
                             e.name, sum, cout, pg, gg,
                             e.sum, e.cout, e.pg, e.gg);
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        foreach (dir[i]) begin
            @(negedge clk);
            rst = dir[i].r;
            a   = dir[i].a;
            b   = dir[i].b;
            cin = dir[i].c;
            e.sum  = dir[i].s;
            e.cout = dir[i].co;
            e.pg   = dir[i].p;
            e.gg   = dir[i].g;
            e.name = dir[i].name;
            q.push_back(e);
        end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rst = (i == 400) || (i == 401) || (i == 777);
            a   = 4'($urandom);
            b   = 4'($urandom);
            cin = 1'($urandom);
            push_model(rst, rst ? "rand_rst" : "rand");
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results left, need 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
